alu_op_sequencer: RTL

- Front-end controller for the ALU.
- Takes single-cycle button pulses from the push-button debouncers and the operand switches, and sequences operand A, operand B and opcode entry.
- Launches the ALU with a start/done handshake, guards it with a timeout, and holds the result for display.
- Sits between the debouncer instances and the ALU core. It supports chaining, where the last result becomes the next A.

---
 rtl/alu_ctrl_pkg.sv | 18 +
 rtl/op_timeout_counter.sv | 37 +++
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU front-end definitions: state encoding and default datapath widths.
// Also consumed by the ALU top and the LED/display decoder.
package alu_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_OPW   = 4;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SHOW    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

endpackage

// File: rtl/op_timeout_counter.sv
// Saturating cycle counter guarding the ALU wait; expired flags the final allowed cycle.
module op_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front-end: sequences operand/opcode entry from button pulses, launches the ALU,
// guards the wait with a timeout and holds the result (optionally chained back into A).
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned OPW     = DEFAULT_OPW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             btn_clear,
    input  logic             btn_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       state_code,
    output logic             busy,
    output logic             err_timeout
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             timer_expired;

    op_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_q == ST_EXEC) || btn_clear),
        .en      (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        if (btn_clear) begin
            state_d = ST_LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: if (btn_enter) begin
                    a_d     = sw;
                    state_d = ST_LOAD_B;
                end
                ST_LOAD_B: if (btn_enter) begin
                    b_d     = sw;
                    state_d = ST_LOAD_OP;
                end
                ST_LOAD_OP: if (btn_enter) begin
                    op_d    = sw[OPW-1:0];
                    state_d = ST_EXEC;
                end
                ST_EXEC: state_d = ST_WAIT;
                // done is checked first so a completion on the final count is not lost
                ST_WAIT: begin
                    if (alu_done) begin
                        res_d   = alu_result;
                        state_d = ST_SHOW;
                    end else if (timer_expired) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_SHOW: begin
                    if (btn_chain) begin
                        a_d     = res_q;
                        state_d = ST_LOAD_B;
                    end else if (btn_enter) begin
                        state_d = ST_LOAD_A;
                    end
                end
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_LOAD_A;
            endcase
        end
    end

    always_comb begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = op_q;
        result      = res_q;
        err_timeout = err_q;
        state_code  = state_q;
        alu_start   = (state_q == ST_EXEC);
        busy        = (state_q == ST_EXEC) || (state_q == ST_WAIT);
    end

endmodule
